aes_arbiter: RTL and testbench

Round-robin arbiter and frame sequencer that shares the byte-serial AES core between two requesters. Each requester submits one 16-byte frame (key load or data block). The arbiter latches the frame's command bits, streams the bytes into the core, collects the 16 result bytes for data frames, and routes them back to the owner. It sits between the on-chip test or user sources and the core, replacing direct single-source wiring.

---
 rtl/aes_arbiter.sv | 143 ++++++++++++++
 tb/tb_aes_arbiter.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_arbiter.sv
// Round-robin arbiter and frame sequencer in front of the byte-serial AES core.
// Two requesters each push one frame; data frames get their 16 result bytes back.
module aes_arbiter #(
   parameter int FRAME_BYTES = 16,
   parameter int TIMEOUT     = 1024
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       r0_req,
   input  logic       r0_cu,
   input  logic       r0_id,
   input  logic [7:0] r0_data,
   input  logic       r0_valid,
   output logic       r0_ready,
   output logic [7:0] r0_rdata,
   output logic       r0_rvalid,
   output logic       r0_done,
   input  logic       r1_req,
   input  logic       r1_cu,
   input  logic       r1_id,
   input  logic [7:0] r1_data,
   input  logic       r1_valid,
   output logic       r1_ready,
   output logic [7:0] r1_rdata,
   output logic       r1_rvalid,
   output logic       r1_done,
   output logic       cu,
   output logic       id,
   output logic [7:0] user_data,
   output logic       shi,
   input  logic [7:0] chip_data,
   input  logic       sho,
   output logic       busy,
   output logic       owner,
   output logic       err,
   output logic       stray
);

   typedef enum logic [1:0] {IDLE, SEND, WAIT_RSP, DONE} state_t;

   localparam int              TW   = $clog2(TIMEOUT) + 1;
   localparam logic [4:0]      LAST = 5'(FRAME_BYTES - 1);
   localparam logic [TW-1:0]   TMAX = TW'(TIMEOUT);

   state_t        state;
   logic          last;
   logic          abort;
   logic [4:0]    cnt;
   logic [TW-1:0] tcnt;
   logic [7:0]    rdata;
   logic          own_valid;
   logic [7:0]    own_data;
   logic          accept;
   logic          grant;

   assign own_valid = owner ? r1_valid : r0_valid;
   assign own_data  = owner ? r1_data  : r0_data;
   assign accept    = (state == SEND) && own_valid;
   // On a tie the requester not served last wins.
   assign grant     = (r0_req && r1_req) ? ~last : r1_req;

   assign busy     = (state != IDLE);
   assign r0_ready = (state == SEND) && !owner;
   assign r1_ready = (state == SEND) &&  owner;
   assign r0_done  = (state == DONE) && !owner;
   assign r1_done  = (state == DONE) &&  owner;
   assign err      = (state == DONE) && abort;
   assign r0_rdata = rdata;
   assign r1_rdata = rdata;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= IDLE;
         last      <= 1'b1;
         abort     <= 1'b0;
         cnt       <= '0;
         tcnt      <= '0;
         owner     <= 1'b0;
         cu        <= 1'b0;
         id        <= 1'b0;
         shi       <= 1'b0;
         user_data <= '0;
         rdata     <= '0;
         r0_rvalid <= 1'b0;
         r1_rvalid <= 1'b0;
         stray     <= 1'b0;
      end else begin
         shi       <= accept;
         r0_rvalid <= 1'b0;
         r1_rvalid <= 1'b0;
         stray     <= sho && (state != WAIT_RSP);
         if (accept) user_data <= own_data;
         unique case (state)
            IDLE: begin
               if (r0_req || r1_req) begin
                  owner <= grant;
                  cu    <= grant ? r1_cu : r0_cu;
                  id    <= grant ? r1_id : r0_id;
                  cnt   <= '0;
                  tcnt  <= '0;
                  abort <= 1'b0;
                  state <= SEND;
               end
            end
            SEND: begin
               if (accept) begin
                  if (cnt == LAST) begin
                     if (cu) begin
                        state <= DONE;
                     end else begin
                        cnt   <= '0;
                        tcnt  <= '0;
                        state <= WAIT_RSP;
                     end
                  end else begin
                     cnt <= cnt + 5'd1;
                  end
               end
            end
            WAIT_RSP: begin
               if (sho) begin
                  rdata     <= chip_data;
                  r0_rvalid <= !owner;
                  r1_rvalid <= owner;
                  tcnt      <= '0;
                  if (cnt == LAST) state <= DONE;
                  else             cnt   <= cnt + 5'd1;
               end else if (tcnt == TMAX) begin
                  abort <= 1'b1;
                  state <= DONE;
               end else begin
                  tcnt <= tcnt + 1'b1;
               end
            end
            DONE: begin
               last  <= owner;
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_aes_arbiter.sv
// Directed bench for aes_arbiter with a 20-stage echo core model
// and queue-based scoreboards for core bytes, responses and done pulses.
module tb_aes_arbiter;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic [1:0] req = '0;
   logic [1:0] cmd = '0;
   logic [1:0] idb = '0;
   logic [1:0] valid = '0;
   logic [7:0] d0 = '0;
   logic [7:0] d1 = '0;
   logic       r0_ready, r1_ready, r0_rvalid, r1_rvalid, r0_done, r1_done;
   logic [7:0] r0_rdata, r1_rdata, user_data, chip_data;
   logic       cu, id, shi, sho, busy, owner, err, stray;
   logic       core_en = 1'b0;
   logic       inj_sho = 1'b0;
   logic [7:0] inj_data = '0;
   logic [8:0] pipe [20];

   int n_cmp = 0;
   int n_mis = 0;
   int n_stray = 0;
   logic [7:0] q_shi [$];
   logic [7:0] q_rd0 [$];
   logic [7:0] q_rd1 [$];
   logic [2:0] q_done [$];

   always #5 clk = ~clk;

   aes_arbiter #(.FRAME_BYTES(16), .TIMEOUT(8)) dut (
      .clk(clk), .rst(rst),
      .r0_req(req[0]), .r0_cu(cmd[0]), .r0_id(idb[0]), .r0_data(d0),
      .r0_valid(valid[0]), .r0_ready(r0_ready), .r0_rdata(r0_rdata),
      .r0_rvalid(r0_rvalid), .r0_done(r0_done),
      .r1_req(req[1]), .r1_cu(cmd[1]), .r1_id(idb[1]), .r1_data(d1),
      .r1_valid(valid[1]), .r1_ready(r1_ready), .r1_rdata(r1_rdata),
      .r1_rvalid(r1_rvalid), .r1_done(r1_done),
      .cu(cu), .id(id), .user_data(user_data), .shi(shi),
      .chip_data(chip_data), .sho(sho),
      .busy(busy), .owner(owner), .err(err), .stray(stray)
   );

   // Core model: every byte comes back inverted 20 cycles later.
   always @(posedge clk) begin
      pipe[0] <= {shi & core_en, user_data ^ 8'hFF};
      for (int i = 1; i < 20; i++) pipe[i] <= pipe[i-1];
   end
   assign sho       = inj_sho | (core_en & pipe[19][8]);
   assign chip_data = inj_sho ? inj_data : pipe[19][7:0];

   task automatic check(input string tag, input logic [63:0] obs,
                        input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_mis++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   always @(negedge clk) begin
      if (rst) begin
         if (shi) begin
            if (q_shi.size() == 0) check("shi_unexp", 64'(shi), 64'd0);
            else check("shi_data", 64'(user_data), 64'(q_shi.pop_front()));
         end
         if (r0_rvalid) begin
            if (q_rd0.size() == 0) check("rd0_unexp", 64'(r0_rvalid), 64'd0);
            else check("rd0_data", 64'(r0_rdata), 64'(q_rd0.pop_front()));
         end
         if (r1_rvalid) begin
            if (q_rd1.size() == 0) check("rd1_unexp", 64'(r1_rvalid), 64'd0);
            else check("rd1_data", 64'(r1_rdata), 64'(q_rd1.pop_front()));
         end
         if (r0_done || r1_done || err) begin
            if (q_done.size() == 0)
               check("done_unexp", 64'({err, r1_done, r0_done}), 64'd0);
            else
               check("done", 64'({err, r1_done, r0_done}),
                     64'(q_done.pop_front()));
         end
         if (stray) n_stray++;
      end
   end

   task automatic feed(input int r, input logic [7:0] base,
                       input int nbytes, input bit toggle);
      int  idx = 0;
      logic acc;
      for (int cyc = 0; cyc < 400 && idx < nbytes; cyc++) begin
         @(negedge clk);
         valid[r] = toggle ? ~cyc[0] : 1'b1;
         if (r == 0) d0 = 8'(base + idx);
         else        d1 = 8'(base + idx);
         acc = valid[r] && (r == 0 ? r0_ready : r1_ready);
         if (acc) begin
            q_shi.push_back(8'(base + idx));
            idx++;
         end
      end
      if (idx < nbytes) check("feed_timeout", 64'(idx), 64'(nbytes));
   endtask

   task automatic end_send(input int r, input bit c);
      @(negedge clk);
      valid[r] = 1'b0;
      check("ready_drop", 64'({r1_ready, r0_ready}), 64'd0);
      if (c) check("key_done", 64'({r1_done, r0_done}), 64'(2'b01 << r));
      else   check("busy_wait", 64'({busy, r1_done, r0_done}), 64'b100);
   endtask

   task automatic wait_done(input int r, input bit ecu, input bit eid);
      bit seen = 1'b0;
      for (int c = 0; c < 2000; c++) begin
         check("cuid_hold", 64'({cu, id}), 64'({ecu, eid}));
         if (r0_done || r1_done) begin
            seen = 1'b1;
            break;
         end
         @(negedge clk);
      end
      if (!seen)
         check("done_timeout", 64'({r1_done, r0_done}), 64'(2'b01 << r));
      req[r] = 1'b0;
   endtask

   task automatic frame(input int r, input bit c, input bit i,
                        input logic [7:0] base, input bit toggle);
      req[r] = 1'b1;
      cmd[r] = c;
      idb[r] = i;
      if (!c && core_en)
         for (int k = 0; k < 16; k++) begin
            if (r == 0) q_rd0.push_back(8'(base + k) ^ 8'hFF);
            else        q_rd1.push_back(8'(base + k) ^ 8'hFF);
         end
      q_done.push_back(r == 0 ? 3'b001 : 3'b010);
      feed(r, base, 16, toggle);
      end_send(r, c);
      wait_done(r, c, i);
   endtask

   initial begin
      foreach (pipe[i]) pipe[i] = '0;
      @(negedge clk);
      check("reset_ctl", 64'({busy, owner, cu, id, shi, r0_ready, r1_ready,
                              r0_rvalid, r1_rvalid, r0_done, r1_done,
                              err, stray}), 64'd0);
      check("reset_dat", 64'({user_data, r0_rdata, r1_rdata}), 64'd0);
      repeat (24) @(negedge clk);
      rst = 1'b1;

      // Data frame with echoed responses
      @(negedge clk);
      core_en = 1'b1;
      frame(0, 1'b0, 1'b1, 8'h00, 1'b0);
      @(negedge clk);
      core_en = 1'b0;
      check("rsp_left", 64'(q_rd0.size()), 64'd0);
      check("shi_left", 64'(q_shi.size()), 64'd0);

      // Key load on r1
      frame(1, 1'b1, 1'b0, 8'h20, 1'b0);
      @(negedge clk);

      // Timeout: core silent
      req[0] = 1'b1;
      cmd[0] = 1'b0;
      idb[0] = 1'b0;
      q_done.push_back(3'b101);
      feed(0, 8'h30, 16, 1'b0);
      end_send(0, 1'b0);
      repeat (8) @(negedge clk);
      check("to_early", 64'({err, r0_done}), 64'd0);
      @(negedge clk);
      check("to_done", 64'({err, r0_done}), 64'b11);
      wait_done(0, 1'b0, 1'b0);
      @(negedge clk);
      frame(1, 1'b1, 1'b0, 8'h40, 1'b0);

      // Stray sho in IDLE
      @(negedge clk);
      @(negedge clk);
      inj_sho  = 1'b1;
      inj_data = 8'h55;
      @(negedge clk);
      inj_sho = 1'b0;
      check("stray_hit", 64'({stray, r0_rvalid, r1_rvalid, busy}), 64'b1000);
      @(negedge clk);
      check("stray_once", 64'(stray), 64'd0);

      // Ties: three rounds, r0 must win each
      for (int n = 0; n < 3; n++) begin
         req = 2'b11;
         cmd = 2'b11;
         idb = 2'b10;
         @(negedge clk);
         check("tie_grant", 64'({owner, r0_ready, r1_ready}), 64'b010);
         frame(0, 1'b1, 1'b0, 8'(8'h50 + 8'(n * 32)), 1'b0);
         frame(1, 1'b1, 1'b1, 8'(8'h60 + 8'(n * 32)), 1'b0);
         @(negedge clk);
      end

      // Back-pressure with non-owner valid held high
      valid[1] = 1'b1;
      d1       = 8'hEE;
      frame(0, 1'b1, 1'b1, 8'hC0, 1'b1);
      valid[1] = 1'b0;
      @(negedge clk);
      check("bp_left", 64'(q_shi.size()), 64'd0);

      // Reset mid-frame after 7 bytes
      req[0] = 1'b1;
      cmd[0] = 1'b0;
      feed(0, 8'hA0, 7, 1'b0);
      @(negedge clk);
      valid[0] = 1'b0;
      req[0]   = 1'b0;
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check("rst_ctl", 64'({busy, owner, cu, id, shi, r0_ready, r1_ready,
                            r0_rvalid, r1_rvalid, r0_done, r1_done,
                            err, stray}), 64'd0);
      check("rst_dat", 64'({user_data, r0_rdata}), 64'd0);
      check("rst_left", 64'(q_shi.size()), 64'd0);
      rst = 1'b1;
      req = 2'b11;
      cmd = 2'b11;
      idb = 2'b00;
      @(negedge clk);
      check("rst_tie", 64'({owner, r0_ready, r1_ready}), 64'b010);
      frame(0, 1'b1, 1'b0, 8'hB0, 1'b0);
      frame(1, 1'b1, 1'b0, 8'hD0, 1'b0);
      repeat (3) @(negedge clk);

      check("end_shi", 64'(q_shi.size()), 64'd0);
      check("end_done", 64'(q_done.size()), 64'd0);
      check("end_stray", 64'(n_stray), 64'd1);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule
